// File: rtl/dc_fu_dma_burst_engine.sv
// AXI4 read DMA for the fetching unit: splits a word-count job into INCR bursts
// that never cross a 4 KB boundary, keeps several in flight, streams data out.
module dc_fu_dma_burst_engine #(
   parameter int unsigned FETCH_WORD_COUNT_WIDTH = 16,
   parameter int unsigned AXI_ARADDR_WIDTH       = 32,
   parameter int unsigned AXI_DATA_WIDTH         = 16,
   parameter int unsigned MAX_BURST_LEN          = 16,
   parameter int unsigned MAX_OUTSTANDING        = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              start_fetch,
   input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
   input  logic [AXI_ARADDR_WIDTH-1:0]       base_addr,
   output logic                              busy,
   output logic                              done,
   output logic [1:0]                        error_flag,
   output logic                              unaligned_read,
   output logic [7:0]                        axi_arid,
   output logic [1:0]                        axi_arlock,
   output logic [3:0]                        axi_arcache,
   output logic [2:0]                        axi_arprot,
   output logic [3:0]                        axi_arqos,
   output logic [3:0]                        axi_arregion,
   output logic [AXI_ARADDR_WIDTH-1:0]       axi_araddr,
   output logic [7:0]                        axi_arlen,
   output logic [2:0]                        axi_arsize,
   output logic [1:0]                        axi_arburst,
   output logic                              axi_arvalid,
   input  logic                              axi_arready,
   input  logic [7:0]                        axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]         axi_rdata,
   input  logic [1:0]                        axi_rresp,
   input  logic                              axi_rlast,
   input  logic                              axi_rvalid,
   output logic                              axi_rready,
   output logic [AXI_DATA_WIDTH-1:0]         out_data,
   output logic                              out_valid,
   output logic                              out_last,
   input  logic                              out_ready
);

   localparam int unsigned CW    = FETCH_WORD_COUNT_WIDTH;
   localparam int unsigned AW    = AXI_ARADDR_WIDTH;
   localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
   localparam int unsigned SIZE  = $clog2(BYTES);
   localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, CHECK, RUN, FINISH} state_t;

   state_t        state;
   logic [AW-1:0] next_addr;
   logic [CW-1:0] ar_remaining;
   logic [CW-1:0] beats_remaining;
   logic [OW-1:0] outstanding;
   logic          arvalid_q;

   logic [12:0]   room_bytes;
   logic [12:0]   room_words;
   logic [31:0]   burst_len;
   logic [8:0]    ar_words;
   logic          ar_hs;
   logic          r_hs;
   logic          issue;
   logic          unused_rid;

   assign axi_arid     = '0;
   assign axi_arlock   = '0;
   assign axi_arcache  = '0;
   assign axi_arprot   = '0;
   assign axi_arqos    = '0;
   assign axi_arregion = '0;
   assign axi_arsize   = 3'(SIZE);
   assign axi_arburst  = 2'b01;
   assign axi_arvalid  = arvalid_q;
   assign unused_rid   = ^axi_rid;

   assign axi_rready = out_ready & en & (state == RUN);
   assign out_valid  = axi_rvalid & (state == RUN);
   assign out_data   = axi_rdata;
   assign out_last   = out_valid & (beats_remaining == CW'(1));

   assign ar_hs    = arvalid_q & axi_arready & en;
   assign r_hs     = axi_rvalid & axi_rready;
   assign ar_words = {1'b0, axi_arlen} + 9'd1;
   assign issue    = (state == RUN) && (ar_remaining != '0) &&
                     (outstanding < OW'(MAX_OUTSTANDING)) && !arvalid_q;

   // Burst length: min of words left to request, max burst, words to the 4 KB line.
   always_comb begin
      room_bytes = 13'h1000 - {1'b0, next_addr[11:0]};
      room_words = room_bytes >> SIZE;
      burst_len  = 32'(ar_remaining);
      if (burst_len > 32'(MAX_BURST_LEN)) burst_len = 32'(MAX_BURST_LEN);
      if (burst_len > 32'(room_words))    burst_len = 32'(room_words);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         error_flag      <= '0;
         unaligned_read  <= 1'b0;
         next_addr       <= '0;
         axi_araddr      <= '0;
         axi_arlen       <= '0;
         arvalid_q       <= 1'b0;
         ar_remaining    <= '0;
         beats_remaining <= '0;
         outstanding     <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start_fetch) begin
                  next_addr       <= base_addr;
                  ar_remaining    <= fetch_word_count;
                  beats_remaining <= fetch_word_count;
                  error_flag      <= '0;
                  unaligned_read  <= 1'b0;
                  busy            <= 1'b1;
                  state           <= CHECK;
               end
            end
            CHECK: begin
               if (SIZE > 0 && (next_addr & AW'(BYTES - 1)) != '0) begin
                  unaligned_read <= 1'b1;
                  done           <= 1'b1;
                  busy           <= 1'b0;
                  state          <= FINISH;
               end else if (ar_remaining == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  arvalid_q  <= 1'b1;
                  axi_araddr <= next_addr;
                  axi_arlen  <= 8'(burst_len - 32'd1);
               end
               if (ar_hs) begin
                  arvalid_q    <= 1'b0;
                  next_addr    <= next_addr + (AW'(ar_words) << SIZE);
                  ar_remaining <= ar_remaining - CW'(ar_words);
               end
               // Simultaneous AR accept and burst completion cancel out.
               case ({ar_hs, r_hs & axi_rlast})
                  2'b10:   outstanding <= outstanding + OW'(1);
                  2'b01:   outstanding <= outstanding - OW'(1);
                  default: outstanding <= outstanding;
               endcase
               if (r_hs) begin
                  beats_remaining <= beats_remaining - CW'(1);
                  if (axi_rresp != 2'b00 && error_flag == 2'b00)
                     error_flag <= axi_rresp;
               end
               if (beats_remaining == '0 && outstanding == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dc_fu_dma_burst_engine.sv
// Randomized bench for dc_fu_dma_burst_engine: AXI read slave plus a burst-plan
// and word-stream reference computed from the job parameters.
module tb_dc_fu_dma_burst_engine;

   localparam int CW  = 16;
   localparam int AW  = 32;
   localparam int DW  = 16;
   localparam int MBL = 16;
   localparam int MO  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          start_fetch;
   logic [CW-1:0] fetch_word_count;
   logic [AW-1:0] base_addr;
   logic          busy, done, unaligned_read;
   logic [1:0]    error_flag;
   logic [7:0]    axi_arid;
   logic [1:0]    axi_arlock;
   logic [3:0]    axi_arcache;
   logic [2:0]    axi_arprot;
   logic [3:0]    axi_arqos;
   logic [3:0]    axi_arregion;
   logic [AW-1:0] axi_araddr;
   logic [7:0]    axi_arlen;
   logic [2:0]    axi_arsize;
   logic [1:0]    axi_arburst;
   logic          axi_arvalid, axi_arready;
   logic [7:0]    axi_rid;
   logic [DW-1:0] axi_rdata;
   logic [1:0]    axi_rresp;
   logic          axi_rlast, axi_rvalid, axi_rready;
   logic [DW-1:0] out_data;
   logic          out_valid, out_last, out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dc_fu_dma_burst_engine #(
      .FETCH_WORD_COUNT_WIDTH(CW),
      .AXI_ARADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(DW),
      .MAX_BURST_LEN(MBL),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .start_fetch(start_fetch),
      .fetch_word_count(fetch_word_count), .base_addr(base_addr),
      .busy(busy), .done(done), .error_flag(error_flag), .unaligned_read(unaligned_read),
      .axi_arid(axi_arid), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
      .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_arregion(axi_arregion),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_at(input logic [31:0] a);
      return a[16:1] ^ a[31:16] ^ 16'h5A3C;
   endfunction

   // mode 0: ideal slave/consumer, 1: random en/ready/valid, 2: out_ready toggles
   task automatic run_job(input logic [31:0] base, input int cnt, input int mode,
                          input bit err_dir, input int abort_at);
      logic [31:0] eaddr[$];
      int          elen[$];
      logic [31:0] saddr[$];
      int          slen[$];
      logic [31:0] a;
      int          rem, room, len;
      int          idx = 0, beat = 0, cycles = 0, outst = 0, k = 0;
      logic [1:0]  first_err = 2'b00;
      bit          got_done = 1'b0, rv = 1'b0, aligned;

      aligned = (base[0] == 1'b0);
      if (aligned) begin
         a = base;
         rem = cnt;
         while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 2;
            len = rem;
            if (len > MBL)  len = MBL;
            if (len > room) len = room;
            eaddr.push_back(a);
            elen.push_back(len - 1);
            a = a + 32'(len * 2);
            rem -= len;
         end
      end

      @(posedge clk); #1;
      en = 1'b1; out_ready = 1'b1;
      start_fetch = 1'b1; base_addr = base; fetch_word_count = CW'(cnt);
      @(posedge clk); #1;
      start_fetch = 1'b0;

      while (!got_done && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         if (abort_at != 0 && cycles == abort_at) begin
            rst = 1'b1;
            #1;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_arvalid", axi_arvalid, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_last", out_last, 0);
            check_eq("rst_rready", axi_rready, 0);
            check_eq("rst_araddr", axi_araddr, 0);
            check_eq("rst_arlen", axi_arlen, 0);
            @(posedge clk); #1;
            rst = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
            return;
         end
         if (done) got_done = 1'b1;
         if (axi_arvalid && eaddr.size() == 0) check_eq("ar_unexpected", axi_arvalid, 0);
         if (axi_rvalid && axi_rready && axi_rlast) outst--;
         if (axi_arvalid && axi_arready && en && eaddr.size() > 0) begin
            check_eq("araddr", axi_araddr, eaddr.pop_front());
            check_eq("arlen", axi_arlen, elen.pop_front());
            saddr.push_back(axi_araddr);
            slen.push_back(int'(axi_arlen));
            outst++;
            check_eq("outstanding_cap", 32'(outst <= MO), 1);
         end
         if (axi_rvalid && axi_rready) begin
            check_eq("out_valid", out_valid, 1);
            check_eq("out_data", out_data, word_at(base + 32'(idx * 2)));
            check_eq("out_last", out_last, 32'(idx == cnt - 1));
            if (axi_rresp != 2'b00 && first_err == 2'b00) first_err = axi_rresp;
            idx++;
            k++;
            if (axi_rlast) begin
               void'(saddr.pop_front());
               void'(slen.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
            rv = 1'b0;
         end
         if (got_done) break;

         @(posedge clk); #1;
         case (mode)
            1: begin
               en = ($urandom_range(0, 9) != 0);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin
               en = 1'b1;
               out_ready = ~out_ready;
            end
            default: begin
               en = 1'b1;
               out_ready = 1'b1;
            end
         endcase
         axi_arready = en && (mode != 1 || $urandom_range(0, 2) != 0);
         if (!rv) begin
            if (saddr.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
               axi_rvalid = 1'b1;
               axi_rdata  = word_at(saddr[0] + 32'(beat * 2));
               axi_rlast  = (beat == slen[0]);
               if (err_dir)
                  axi_rresp = (k == 2) ? 2'b10 : ((k == 4) ? 2'b11 : 2'b00);
               else
                  axi_rresp = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
               rv = 1'b1;
            end else begin
               axi_rvalid = 1'b0;
               axi_rlast  = 1'b0;
            end
         end
      end

      en = 1'b1;
      check_eq("done_seen", 32'(got_done), 1);
      check_eq("beats_delivered", idx, (aligned ? cnt : 0));
      check_eq("bursts_left", eaddr.size(), 0);
      check_eq("error_flag", error_flag, first_err);
      check_eq("unaligned_read", unaligned_read, 32'(!aligned));
      check_eq("busy_at_done", busy, 0);
      if (err_dir) check_eq("error_first_only", error_flag, 2'b10);
      if (mode == 0 && (!aligned || cnt == 0)) check_eq("done_latency", cycles, 2);
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("unaligned_hold", unaligned_read, 32'(!aligned));
      axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
   endtask

   initial begin
      logic [31:0] rb;
      logic [11:0] off;
      rst = 1'b1; en = 1'b0; start_fetch = 1'b0; fetch_word_count = '0; base_addr = '0;
      axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0;
      axi_rlast = 1'b0; axi_rvalid = 1'b0; out_ready = 1'b1;
      #2;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_arvalid", axi_arvalid, 0);
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_error", error_flag, 0);
      check_eq("reset_araddr", axi_araddr, 0);
      check_eq("arsize", axi_arsize, 1);
      check_eq("arburst", axi_arburst, 1);
      @(posedge clk); #1;
      rst = 1'b0;

      run_job(32'h0000_1000, 40, 0, 1'b0, 0);
      run_job(32'h0000_0FF0, 20, 0, 1'b0, 0);
      run_job(32'h0000_2000, 16, 2, 1'b0, 0);
      run_job(32'h0000_3000, 16, 0, 1'b1, 0);
      run_job(32'h0000_1001, 8,  0, 1'b0, 0);
      run_job(32'h0000_2000, 0,  0, 1'b0, 0);
      run_job(32'h0000_4000, 64, 0, 1'b0, 12);
      run_job(32'h0000_5FE0, 64, 1, 1'b0, 0);
      for (int i = 0; i < 14; i++) begin
         rb  = $urandom;
         off = 12'(12'hF00 + 12'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 0) off = 12'($urandom);
         off[0] = 1'b0;
         run_job({rb[31:12], off}, $urandom_range(1, 90), 1, 1'b0, 0);
      end
      run_job(32'hFFFF_FFE0, 40, 1, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dc_fu_dma_burst_engine.md
Name: dc_fu_dma_burst_engine

Overview:
Parametrised AXI4 read DMA for the fetching unit. It fetches fetch_word_count bus-width words from base_addr and keeps up to MAX_OUTSTANDING bursts in flight. Bursts are split so none crosses a 4 KB boundary. Read data is returned on a valid/ready stream with a last-word marker, so the consumer can apply backpressure.

Parameters:
FETCH_WORD_COUNT_WIDTH, 16, width of the word-count input
AXI_ARADDR_WIDTH, 32, AXI read address width
AXI_DATA_WIDTH, 16, AXI read data width in bits (power of two, 8..256); axi_arsize = log2(AXI_DATA_WIDTH/8)
MAX_BURST_LEN, 16, maximum beats per burst (1..256)
MAX_OUTSTANDING, 4, maximum bursts accepted on AR but not yet completed on R (1..16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  clock enable; low freezes all state
start_fetch  in  1  single-cycle start request, sampled only in IDLE
fetch_word_count  in  FETCH_WORD_COUNT_WIDTH  number of words to fetch
base_addr  in  AXI_ARADDR_WIDTH  start byte address
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the job ends
error_flag  out  2  first non-OKAY rresp of the job, sticky
unaligned_read  out  1  base_addr not aligned to bus width, sticky
axi_arid/arlock/arcache/arprot/arqos/arregion  out  8/2/4/3/4/4  constant 0
axi_araddr  out  AXI_ARADDR_WIDTH  burst address
axi_arlen  out  8  beats minus 1
axi_arsize  out  3  constant log2(AXI_DATA_WIDTH/8)
axi_arburst  out  2  constant 2'b01 (INCR)
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rid  in  8  ignored
axi_rdata  in  AXI_DATA_WIDTH  read data
axi_rresp  in  2  read response
axi_rlast  in  1  last beat of burst
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready
out_data  out  AXI_DATA_WIDTH  fetched word (= axi_rdata)
out_valid  out  1  word valid
out_last  out  1  final word of job
out_ready  in  1  consumer ready

Behaviour:
- Reset values: busy, done, axi_arvalid, out_valid, out_last = 0; error_flag = 0; unaligned_read = 0; axi_araddr = 0; axi_arlen = 0; all internal counters = 0; state = IDLE.
- The state machine has four states: IDLE, CHECK, RUN and FINISH.
- IDLE, on start_fetch with en high:
  - Latch base_addr and fetch_word_count.
  - Clear error_flag and unaligned_read.
  - Set busy.
  - Go to CHECK.
- CHECK (one cycle):
  - If the base_addr low log2(AXI_DATA_WIDTH/8) bits are non-zero, set unaligned_read and go to FINISH.
  - Else if the word count is 0, go to FINISH.
  - Else go to RUN.
- RUN, AR side:
  - Keep two counters: ar_remaining (words not yet requested) and beats_remaining (words not yet delivered).
  - When ar_remaining > 0, outstanding < MAX_OUTSTANDING and arvalid is low, assert arvalid. On that cycle drive araddr and arlen = min(ar_remaining, MAX_BURST_LEN, words left to the next 4 KB boundary) - 1.
  - Hold arvalid, araddr and arlen stable until the arready handshake.
  - On the handshake: advance the address by (arlen+1)*bytes, subtract from ar_remaining, and increment outstanding.
- RUN, R side:
  - axi_rready = out_ready & en & (state==RUN). out_valid = axi_rvalid & (state==RUN). out_data = axi_rdata (combinational).
  - On each R handshake, decrement beats_remaining.
  - On a handshake with rlast, decrement outstanding. A simultaneous AR handshake and rlast handshake leave outstanding unchanged.
  - out_last = out_valid & (beats_remaining==1).
  - The first handshake with rresp != 2'b00 latches rresp into error_flag. Later errors do not overwrite it. The data is still forwarded and the job continues to completion.
- RUN to FINISH when beats_remaining==0 and outstanding==0.
- FINISH: pulse done for one cycle, clear busy, return to IDLE. unaligned_read and error_flag hold until the next accepted start.
- start_fetch outside IDLE is ignored.
- en low:
  - No state, counter or address changes.
  - axi_rready is forced to 0.
  - An asserted arvalid stays asserted with stable payload (AXI rule), but a handshake occurring while en is low is not counted. For that reason the slave must not see arready honoured: arvalid is gated to 0 only if it was not yet asserted.
- rst asserted mid-job: everything returns to reset values immediately. The in-flight AXI transactions are abandoned; the system resets the interconnect together with this block.
- Arithmetic: counters are FETCH_WORD_COUNT_WIDTH wide; outstanding is $clog2(MAX_OUTSTANDING+1) wide; the address wraps modulo 2^AXI_ARADDR_WIDTH.

Test Plan:
- base 0x1000, count 40, MAX_BURST_LEN 16, data 16 bit, slave always ready -> AR bursts arlen 15/15/7 at 0x1000/0x1020/0x1040; 40 out beats with out_last on beat 40; done one cycle after the last beat.
- base 0x0FF0, count 20 -> bursts at 0x0FF0 arlen 7 and 0x1000 arlen 11; no burst crosses 0x1000.
- MAX_OUTSTANDING 2, slave delays R by 20 cycles, count 64 -> a third arvalid is not asserted until the first rlast completes; outstanding never exceeds 2.
- out_ready toggled 1010..., count 16 -> rready mirrors out_ready; all 16 words are delivered in order with no duplicates.
- rresp 2'b10 on beat 3, 2'b11 on beat 5 -> error_flag = 2'b10 and sticky; all beats still delivered; done pulses.
- base 0x1001 -> unaligned_read = 1; no arvalid; done two cycles after start. Count 0 -> done with no AXI traffic. rst mid-burst -> all outputs are 0 in the same cycle.
